// File: rtl/sound_arbiter.sv
// Speaker arbiter: fixed-priority choice between the live lamp tone and three
// event jingles, with a note-ROM sequencer and a reloadable square-wave divider.
module sound_arbiter #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int NOTE_CYC = 7_500_000
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [1:0] LAMP,
   input  logic       LAMP_ENA,
   input  logic       WIN,
   input  logic       LOSE,
   input  logic       HS,
   output logic       SPK,
   output logic       SND_ON,
   output logic       BUSY,
   output logic [2:0] NOTE_IDX
);

   localparam int HP0   = CLK_FREQ / (2 * 209);
   localparam int HP1   = CLK_FREQ / (2 * 252);
   localparam int HP2   = CLK_FREQ / (2 * 310);
   localparam int HP3   = CLK_FREQ / (2 * 415);
   localparam int HP4   = CLK_FREQ / (2 * 42);
   localparam int DIV_W = $clog2(HP4 + 1);
   localparam int TMR_W = $clog2(NOTE_CYC + 1);

   localparam logic [TMR_W-1:0] NOTE_LAST = TMR_W'(NOTE_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAMP,
      S_JINGLE
   } state_t;

   // Encoding doubles as priority: a larger value preempts a smaller one.
   typedef enum logic [1:0] {
      J_NONE = 2'd0,
      J_HS   = 2'd1,
      J_WIN  = 2'd2,
      J_LOSE = 2'd3
   } jingle_t;

   state_t           state_q, state_d;
   jingle_t          jid_q, jid_d;
   jingle_t          req_id, cur_prio;
   logic [2:0]       slot_q, slot_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [2:0]       idx_q, idx_d;
   logic [DIV_W-1:0] div_q;
   logic             spk_q;
   logic             win_p0, lose_p0, hs_p0, armed_p0;
   logic             rise_win, rise_lose, rise_hs;
   logic             start, restart, on_d, tone_chg;

   function automatic logic [2:0] rom_tone(input jingle_t id, input logic [2:0] slot);
      logic [2:0] t;
      t = 3'd0;
      case (id)
         J_WIN: begin
            case (slot)
               3'd0:    t = 3'd0;
               3'd1:    t = 3'd1;
               3'd2:    t = 3'd2;
               default: t = 3'd3;
            endcase
         end
         J_HS:    t = slot[0] ? 3'd2 : 3'd3;
         J_LOSE:  t = 3'd4;
         default: t = 3'd0;
      endcase
      return t;
   endfunction

   function automatic logic [2:0] rom_last(input jingle_t id);
      logic [2:0] l;
      case (id)
         J_WIN:   l = 3'd4;
         J_HS:    l = 3'd5;
         J_LOSE:  l = 3'd3;
         default: l = 3'd0;
      endcase
      return l;
   endfunction

   function automatic logic [DIV_W-1:0] half_period(input logic [2:0] idx);
      logic [DIV_W-1:0] hp;
      case (idx)
         3'd0:    hp = DIV_W'(HP0 - 1);
         3'd1:    hp = DIV_W'(HP1 - 1);
         3'd2:    hp = DIV_W'(HP2 - 1);
         3'd3:    hp = DIV_W'(HP3 - 1);
         default: hp = DIV_W'(HP4 - 1);
      endcase
      return hp;
   endfunction

   // armed_p0 masks the first cycle after reset so a flag held high through
   // reset is not mistaken for a fresh rising edge.
   assign rise_win  = armed_p0 & WIN  & ~win_p0;
   assign rise_lose = armed_p0 & LOSE & ~lose_p0;
   assign rise_hs   = armed_p0 & HS   & ~hs_p0;

   always_comb begin
      req_id = J_NONE;
      if (rise_lose)     req_id = J_LOSE;
      else if (rise_win) req_id = J_WIN;
      else if (rise_hs)  req_id = J_HS;
   end

   assign cur_prio = (state_q == S_JINGLE) ? jid_q : J_NONE;
   assign start    = (req_id != J_NONE) && (req_id > cur_prio);

   always_comb begin
      state_d = state_q;
      jid_d   = jid_q;
      slot_d  = slot_q;
      tmr_d   = tmr_q;
      restart = 1'b0;
      if (start) begin
         state_d = S_JINGLE;
         jid_d   = req_id;
         slot_d  = 3'd0;
         tmr_d   = NOTE_LAST;
         restart = 1'b1;
      end else if (state_q == S_JINGLE) begin
         if (tmr_q != '0) begin
            tmr_d = tmr_q - 1'b1;
         end else if (slot_q != rom_last(jid_q)) begin
            slot_d = slot_q + 3'd1;
            tmr_d  = NOTE_LAST;
         end else begin
            state_d = LAMP_ENA ? S_LAMP : S_IDLE;
            jid_d   = J_NONE;
            slot_d  = 3'd0;
            tmr_d   = '0;
         end
      end else begin
         state_d = LAMP_ENA ? S_LAMP : S_IDLE;
      end
   end

   always_comb begin
      case (state_d)
         S_JINGLE: idx_d = rom_tone(jid_d, slot_d);
         S_LAMP:   idx_d = {1'b0, LAMP};
         default:  idx_d = 3'd0;
      endcase
   end

   // A jingle restart reloads the divider even if the first note matches.
   assign on_d     = (state_d != S_IDLE);
   assign tone_chg = on_d && ((state_q == S_IDLE) || (idx_d != idx_q) || restart);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= S_IDLE;
         jid_q    <= J_NONE;
         slot_q   <= 3'd0;
         tmr_q    <= '0;
         idx_q    <= 3'd0;
         win_p0   <= 1'b0;
         lose_p0  <= 1'b0;
         hs_p0    <= 1'b0;
         armed_p0 <= 1'b0;
      end else begin
         state_q  <= state_d;
         jid_q    <= jid_d;
         slot_q   <= slot_d;
         tmr_q    <= tmr_d;
         idx_q    <= idx_d;
         win_p0   <= WIN;
         lose_p0  <= LOSE;
         hs_p0    <= HS;
         armed_p0 <= 1'b1;
      end
   end

   // Divider: reload on tone change with SPK held, toggle on terminal count.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         div_q <= '0;
         spk_q <= 1'b0;
      end else if (!on_d) begin
         div_q <= '0;
         spk_q <= 1'b0;
      end else if (tone_chg) begin
         div_q <= half_period(idx_d);
      end else if (div_q == '0) begin
         div_q <= half_period(idx_q);
         spk_q <= ~spk_q;
      end else begin
         div_q <= div_q - 1'b1;
      end
   end

   assign SPK      = spk_q;
   assign SND_ON   = (state_q != S_IDLE);
   assign BUSY     = (state_q == S_JINGLE);
   assign NOTE_IDX = idx_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// Directed bench for sound_arbiter at CLK_FREQ=100_000, NOTE_CYC=16
// (HP0=239, HP1=198, HP2=161, HP3=120, HP4=1190; 16 clocks per note).
module tb_sound_arbiter;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic [1:0] LAMP = 2'd0;
   logic       LAMP_ENA = 1'b0;
   logic       WIN = 1'b0;
   logic       LOSE = 1'b0;
   logic       HS = 1'b0;
   logic       SPK;
   logic       SND_ON;
   logic       BUSY;
   logic [2:0] NOTE_IDX;

   int n_tests = 0;
   int n_fail  = 0;

   int win_rom[5] = '{0, 1, 2, 3, 3};
   int hs_rom[6]  = '{3, 2, 3, 2, 3, 2};

   logic [4:0] obs, exp_o;
   logic       exp_spk;

   sound_arbiter #(
      .CLK_FREQ(100_000),
      .NOTE_CYC(16)
   ) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .LAMP     (LAMP),
      .LAMP_ENA (LAMP_ENA),
      .WIN      (WIN),
      .LOSE     (LOSE),
      .HS       (HS),
      .SPK      (SPK),
      .SND_ON   (SND_ON),
      .BUSY     (BUSY),
      .NOTE_IDX (NOTE_IDX)
   );

   always #5 CLK = ~CLK;

   assign obs = {SND_ON, BUSY, NOTE_IDX};

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      WIN   = 1'b1;
      repeat (3) tick();
      n_tests++;
      if ({SPK, obs} !== 6'd0) begin
         n_fail++;
         $display("FAIL reset_hold: got {spk,on,busy,idx}=%b want 000000", {SPK, obs});
      end
      RST_N = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         n_tests++;
         if ({SPK, obs} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_win_held edge %0d: got {spk,on,busy,idx}=%b want 000000", k, {SPK, obs});
         end
      end
      WIN = 1'b0;
      tick();
   endtask

   task automatic test_lamp();
      LAMP     = 2'd2;
      LAMP_ENA = 1'b1;
      for (int k = 1; k <= 170; k++) begin
         tick();
         exp_o   = {1'b1, 1'b0, 3'd2};
         exp_spk = 1'(((k - 1) / 161) % 2);
         n_tests++;
         if (obs !== exp_o || SPK !== exp_spk) begin
            n_fail++;
            $display("FAIL lamp2 edge %0d: got obs=%b spk=%b want obs=%b spk=%b", k, obs, SPK, exp_o, exp_spk);
         end
      end
      LAMP = 2'd3;
      for (int k = 171; k <= 420; k++) begin
         tick();
         exp_o   = {1'b1, 1'b0, 3'd3};
         exp_spk = 1'b1 ^ 1'(((k - 171) / 120) % 2);
         n_tests++;
         if (obs !== exp_o || SPK !== exp_spk) begin
            n_fail++;
            $display("FAIL lamp3 edge %0d: got obs=%b spk=%b want obs=%b spk=%b", k, obs, SPK, exp_o, exp_spk);
         end
      end
      LAMP_ENA = 1'b0;
      tick();
      n_tests++;
      if ({SPK, obs} !== 6'd0) begin
         n_fail++;
         $display("FAIL lamp_off: got {spk,on,busy,idx}=%b want 000000", {SPK, obs});
      end
      LAMP = 2'd0;
      tick();
   endtask

   task automatic test_win();
      WIN = 1'b1;
      for (int k = 1; k <= 84; k++) begin
         tick();
         if (k == 1) WIN = 1'b0;
         exp_o = (k <= 80) ? {1'b1, 1'b1, 3'(win_rom[(k - 1) / 16])} : 5'd0;
         n_tests++;
         if (obs !== exp_o || SPK !== 1'b0) begin
            n_fail++;
            $display("FAIL win edge %0d: got obs=%b spk=%b want obs=%b spk=0", k, obs, SPK, exp_o);
         end
      end
   endtask

   task automatic test_preempt();
      HS = 1'b1;
      for (int k = 1; k <= 110; k++) begin
         tick();
         if (k <= 36)       exp_o = {1'b1, 1'b1, 3'(hs_rom[(k - 1) / 16])};
         else if (k <= 100) exp_o = {1'b1, 1'b1, 3'd4};
         else               exp_o = 5'd0;
         n_tests++;
         if (obs !== exp_o || SPK !== 1'b0) begin
            n_fail++;
            $display("FAIL preempt edge %0d: got obs=%b spk=%b want obs=%b spk=0", k, obs, SPK, exp_o);
         end
         if (k == 1)  HS   = 1'b0;
         if (k == 36) LOSE = 1'b1;
         if (k == 37) LOSE = 1'b0;
         if (k == 50) WIN  = 1'b1;
         if (k == 52) WIN  = 1'b0;
      end
   endtask

   task automatic test_simultaneous();
      WIN = 1'b1;
      HS  = 1'b1;
      for (int k = 1; k <= 90; k++) begin
         tick();
         exp_o = (k <= 80) ? {1'b1, 1'b1, 3'(win_rom[(k - 1) / 16])} : 5'd0;
         n_tests++;
         if (obs !== exp_o) begin
            n_fail++;
            $display("FAIL simul edge %0d: got obs=%b want obs=%b", k, obs, exp_o);
         end
         if (k == 1) begin
            WIN = 1'b0;
            HS  = 1'b0;
         end
         if (k == 20) WIN = 1'b1;
         if (k == 22) WIN = 1'b0;
         if (k == 40) HS  = 1'b1;
         if (k == 42) HS  = 1'b0;
      end
   endtask

   task automatic test_lamp_masked();
      LAMP     = 2'd1;
      LAMP_ENA = 1'b1;
      WIN      = 1'b1;
      for (int k = 1; k <= 480; k++) begin
         tick();
         if (k == 1) WIN = 1'b0;
         if (k <= 80) begin
            exp_o   = {1'b1, 1'b1, 3'(win_rom[(k - 1) / 16])};
            exp_spk = 1'b0;
         end else begin
            exp_o   = {1'b1, 1'b0, 3'd1};
            exp_spk = 1'(((k - 81) / 198) % 2);
         end
         n_tests++;
         if (obs !== exp_o || SPK !== exp_spk) begin
            n_fail++;
            $display("FAIL masked edge %0d: got obs=%b spk=%b want obs=%b spk=%b", k, obs, SPK, exp_o, exp_spk);
         end
      end
      LAMP_ENA = 1'b0;
      tick();
      n_tests++;
      if ({SPK, obs} !== 6'd0) begin
         n_fail++;
         $display("FAIL masked_off: got {spk,on,busy,idx}=%b want 000000", {SPK, obs});
      end
   endtask

   initial begin
      test_reset();
      test_lamp();
      test_win();
      test_preempt();
      test_simultaneous();
      test_lamp_masked();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
